// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: ALU operation codes, controller states and default cycle counts.
package mdu_ctrl_pkg;

   localparam logic [4:0] SIG_ALU_MULT  = 5'h18;
   localparam logic [4:0] SIG_ALU_MULTU = 5'h19;
   localparam logic [4:0] SIG_ALU_DIV   = 5'h1A;
   localparam logic [4:0] SIG_ALU_DIVU  = 5'h1B;
   localparam logic [4:0] SIG_ALU_MTHI  = 5'h1C;
   localparam logic [4:0] SIG_ALU_MTLO  = 5'h1D;

   localparam int MDU_MUL_CYCLES_DEF = 2;
   localparam int MDU_DIV_ITERS_DEF  = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } mdu_state_e;

   // Magnitude of v when interpreted as signed; passthrough for unsigned ops.
   function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring divider core: the load edge performs the first iteration, one iteration per cycle after.
module div_radix2 #(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        valid,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] r_rem, r_quo, r_dvs;
   logic [5:0]  r_cnt;
   logic        r_busy, r_valid;
   logic [63:0] w_ld_step, w_it_step;

   function automatic logic [63:0] step(input logic [31:0] rem, input logic [31:0] quo,
                                        input logic [31:0] dvs);
      logic [32:0] sh;
      sh = {rem, quo[31]};
      if (sh >= {1'b0, dvs}) begin
         sh = sh - {1'b0, dvs};
         return {sh[31:0], quo[30:0], 1'b1};
      end
      return {sh[31:0], quo[30:0], 1'b0};
   endfunction

   // Fewer iterations divide only the low ITERS bits of the dividend.
   assign w_ld_step = step(32'd0, dividend << (32 - ITERS), divisor);
   assign w_it_step = step(r_rem, r_quo, r_dvs);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else if (load) begin
         {r_rem, r_quo} <= w_ld_step;
         r_dvs   <= divisor;
         r_cnt   <= 6'(ITERS - 1);
         r_busy  <= (ITERS > 1);
         r_valid <= (ITERS == 1);
      end else if (r_busy) begin
         {r_rem, r_quo} <= w_it_step;
         r_cnt <= r_cnt - 6'd1;
         if (r_cnt == 6'd1) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
         end
      end
   end

   assign busy      = r_busy;
   assign valid     = r_valid;
   assign quotient  = r_quo;
   assign remainder = r_rem;

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS EX-stage multiply/divide controller owning HI/LO; stalls the pipe while busy, aborts on flush.
// Define MDU_EARLY_OUT_EN to finish divide-by-zero and |a|<|b| divides in a single cycle.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
   parameter int DIV_ITERS  = MDU_DIV_ITERS_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [4:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MUL_LD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

   mdu_state_e  r_state, w_nxt;
   logic [31:0] r_a, r_b;
   logic [3:0]  r_cnt;
   logic        r_signed, r_dz, r_sq, r_sr;
   logic        w_is_mul, w_is_div, w_signed, w_accept, w_mt, w_early;
   logic        w_div_load, w_div_busy, w_div_valid, w_wr_mul, w_wr_div, w_wr_eo;
   logic [31:0] w_abs_a, w_abs_b, w_core_q, w_core_r, w_div_hi, w_div_lo, w_ma, w_mb;
   logic [63:0] w_xa, w_xb, w_prod;

   assign w_is_mul = (op == SIG_ALU_MULT) || (op == SIG_ALU_MULTU);
   assign w_is_div = (op == SIG_ALU_DIV)  || (op == SIG_ALU_DIVU);
   assign w_signed = (op == SIG_ALU_MULT) || (op == SIG_ALU_DIV);
   assign w_accept = resetn && (r_state == S_IDLE) && start && !flush && (w_is_mul || w_is_div);
   assign w_mt     = (r_state == S_IDLE) && start && !flush &&
                     ((op == SIG_ALU_MTHI) || (op == SIG_ALU_MTLO));
   assign w_abs_a  = mdu_abs(a, w_signed);
   assign w_abs_b  = mdu_abs(b, w_signed);

`ifdef MDU_EARLY_OUT_EN
   assign w_early = w_is_div && ((b == 32'd0) || (w_abs_a < w_abs_b));
`else
   assign w_early = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) begin
            if (w_is_mul) w_nxt = (MUL_CYCLES == 1) ? S_DONE : S_MUL;
            else          w_nxt = w_early ? S_DONE : S_DIV;
         end
         S_MUL:  if (flush) w_nxt = S_IDLE;
                 else if (r_cnt == 4'd0) w_nxt = S_DONE;
         S_DIV:  if (flush) w_nxt = S_IDLE;
                 else if (w_div_valid && !w_div_busy) w_nxt = S_DONE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall      = w_accept || (((r_state == S_MUL) || (r_state == S_DIV)) && !flush);
      done       = (r_state == S_DONE);
      w_div_load = w_accept && w_is_div && !w_early;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_signed <= 1'b0;
         r_dz     <= 1'b0;
         r_sq     <= 1'b0;
         r_sr     <= 1'b0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_cnt    <= MUL_LD;
         r_signed <= w_signed;
         r_dz     <= (b == 32'd0);
         r_sq     <= w_signed && (a[31] ^ b[31]);
         r_sr     <= w_signed && a[31];
      end else if ((r_state == S_MUL) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // A single-cycle multiply must use the live operands, otherwise the latched ones.
   assign w_ma   = (r_state == S_IDLE) ? a : r_a;
   assign w_mb   = (r_state == S_IDLE) ? b : r_b;
   assign w_xa   = (((r_state == S_IDLE) ? w_signed : r_signed) && w_ma[31]) ? {32'hFFFFFFFF, w_ma}
                                                                             : {32'd0, w_ma};
   assign w_xb   = (((r_state == S_IDLE) ? w_signed : r_signed) && w_mb[31]) ? {32'hFFFFFFFF, w_mb}
                                                                             : {32'd0, w_mb};
   assign w_prod = w_xa * w_xb;

   assign w_div_lo = r_dz ? 32'hFFFFFFFF : (r_sq ? (32'd0 - w_core_q) : w_core_q);
   assign w_div_hi = r_dz ? r_a          : (r_sr ? (32'd0 - w_core_r) : w_core_r);

   assign w_wr_mul = ((r_state == S_MUL) && !flush && (r_cnt == 4'd0)) ||
                     (w_accept && w_is_mul && (MUL_CYCLES == 1));
   assign w_wr_div = (r_state == S_DIV) && !flush && w_div_valid && !w_div_busy;
   assign w_wr_eo  = w_accept && w_early;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi <= '0;
         lo <= '0;
      end else if (w_wr_mul) begin
         hi <= w_prod[63:32];
         lo <= w_prod[31:0];
      end else if (w_wr_div) begin
         hi <= w_div_hi;
         lo <= w_div_lo;
      end else if (w_wr_eo) begin
         hi <= a;
         lo <= (b == 32'd0) ? 32'hFFFFFFFF : 32'd0;
      end else if (w_mt) begin
         if (op == SIG_ALU_MTHI) hi <= a;
         else                    lo <= a;
      end
   end

   div_radix2 #(.ITERS(DIV_ITERS)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .load      (w_div_load),
      .dividend  (w_abs_a),
      .divisor   (w_abs_b),
      .busy      (w_div_busy),
      .valid     (w_div_valid),
      .quotient  (w_core_q),
      .remainder (w_core_r)
   );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed MUL/DIV/MT vectors, flush, reset and early-out latency.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int MC = 2;
   localparam int DI = 32;
`ifdef MDU_EARLY_OUT_EN
   localparam int NE = 1;
`else
   localparam int NE = DI + 1;
`endif
   localparam int ND = DI + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        flush = 1'b0;
   logic        stall, done;
   logic [31:0] hi, lo;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   run = 0;

   mdu_ctrl #(.MUL_CYCLES(MC), .DIV_ITERS(DI)) dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse consumes one expected result and the preceding stall run.
   always @(negedge clk) begin
      if (!resetn) run = 0;
      else if (done) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none (hi=%h lo=%h)", hi, lo);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_hi", hi, e.hi);
            chk("sb_lo", lo, e.lo);
            chk("sb_stall_cycles", 32'(run), 32'(e.n));
         end
         run = 0;
      end else if (stall) run++;
      else run = 0;
   end

   task automatic do_op(input logic [4:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] eh, input logic [31:0] el, input int n);
      int  cyc;
      bit  got;
      exp_t e;
      e.hi = eh; e.lo = el; e.n = n;
      sb_q.push_back(e);
      start = 1'b1; op = o; a = xa; b = xb;
      cyc = 0; got = 0;
      while (!got && cyc < 100) begin
         @(posedge clk); #1;
         a = $urandom; b = $urandom;
         cyc++;
         if (done) got = 1;
      end
      if (!got) chk("op_timeout", 32'(cyc), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; a = '0; b = '0;
   endtask

   initial begin
      #12;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;
      @(posedge clk); #1;

      do_op(SIG_ALU_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC);
      do_op(SIG_ALU_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MC);
      do_op(SIG_ALU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, MC);
      do_op(SIG_ALU_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, ND);
      do_op(SIG_ALU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, ND);
      do_op(SIG_ALU_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, ND);
      do_op(SIG_ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, ND);
      do_op(SIG_ALU_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, NE);
      do_op(SIG_ALU_DIV,   32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, NE);
      do_op(SIG_ALU_DIVU,  32'd3, 32'd10, 32'd3, 32'd0, NE);

      // Flush a divide at its 10th cycle: nothing retires, HI/LO untouched.
      start = 1'b1; op = SIG_ALU_DIVU; a = 32'd1000; b = 32'd3;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      #1 chk("flush_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      #1 chk("post_flush_stall", {31'd0, stall}, 32'd0);
      repeat (40) begin @(posedge clk); #1; end
      chk("flush_hi_kept", hi, 32'd3);
      chk("flush_lo_kept", lo, 32'd0);

      start = 1'b1; op = SIG_ALU_MTLO; a = 32'h1234;
      #1 chk("mtlo_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("mtlo_lo", lo, 32'h1234);
      chk("mtlo_hi", hi, 32'd3);
      start = 1'b1; op = SIG_ALU_MTHI; a = 32'hCAFE0001;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mthi_hi", hi, 32'hCAFE0001);
      chk("mthi_lo", lo, 32'h1234);

      // Flush together with start, then an unknown op: neither is accepted.
      start = 1'b1; op = SIG_ALU_DIV; a = 32'd9; b = 32'd2; flush = 1'b1;
      #1 chk("flush_start_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; op = 5'h00;
      #1 chk("noaccept_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("badop_stall", {31'd0, stall}, 32'd0);
      start = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a divide.
      start = 1'b1; op = SIG_ALU_DIVU; a = 32'd77; b = 32'd5;
      repeat (5) begin @(posedge clk); #1; end
      chk("middiv_stall", {31'd0, stall}, 32'd1);
      resetn = 1'b0; start = 1'b0;
      #1;
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      chk("rst_mid_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;

      do_op(SIG_ALU_DIVU, 32'd77, 32'd5, 32'd2, 32'd15, ND);
      repeat (3) begin @(posedge clk); #1; end
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
